dst_demux: RTL
==============

# dst_demux

Writeback destination controller: the write-side counterpart of the datapath source select. It accepts one result word per transaction and routes it to a single destination: register file, data memory, I/O space, PC or SP. It sits between the execute stage and the state-holding units. Register, PC and SP writes are single-cycle strobes. Memory and I/O writes run a req/ack handshake with a timeout.

## Interface
- DATA_W, 16, width of data and address words
- ACK_TIMEOUT, 15, maximum cycles `mem_req`/`io_req` is held without ack before abort (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  controller can accept; equals (state==IDLE)
- dst_sel  in  3  destination: 000 reg, 010 mem, 011 io, 100 pc, 101 sp; 001/110/111 invalid
- wb_data  in  DATA_W  result word
- wb_addr  in  DATA_W  mem/io address
- wb_rd  in  3  register index
- rf_we  out  1  register file write strobe
- rf_waddr  out  3  register index
- rf_wdata  out  DATA_W  register write data
- mem_req  out  1  memory write request
- mem_addr, mem_wdata  out  DATA_W  memory address/data
- mem_ack  in  1  memory write accepted
- io_req  out  1  I/O write request
- io_addr, io_wdata  out  DATA_W  I/O address/data
- io_ack  in  1  I/O write accepted
- pc_load  out  1  PC load strobe
- pc_next  out  DATA_W  new PC
- sp_load  out  1  SP load strobe
- sp_next  out  DATA_W  new SP
- err  out  1  one-cycle pulse: invalid dst_sel or handshake timeout

## Operation
- All outputs registered except wb_ready.
- FSM states: IDLE, MEM_WAIT, IO_WAIT.
- Accept: an edge where wb_valid && wb_ready. dst_sel, wb_data, wb_addr and wb_rd are captured at that edge.
- IDLE, reg/pc/sp accept: the matching strobe goes high for exactly the next cycle, with the data/index on its bus. State stays IDLE, so back-to-back accepts every cycle are legal.
- IDLE, mem accept: go to MEM_WAIT. Timeout counter cleared. mem_req=1 with mem_addr/mem_wdata from the captured values.
- IDLE, io accept: same as mem, using IO_WAIT and io_* signals.
- IDLE, invalid dst_sel accept: transaction dropped. err=1 next cycle. No strobe or req.
- MEM_WAIT/IO_WAIT, ack sampled high at an edge: req drops, go to IDLE.
- MEM_WAIT/IO_WAIT, no ack: counter increments. An edge with counter==ACK_TIMEOUT-1 and no ack aborts: req drops, err=1 next cycle, go to IDLE.
- Ack sampled in the same cycle as the timeout condition: ack wins, no err.
- Address/data buses hold stable for the whole req assertion. They hold their last values after completion.
- Strobe data buses hold last values when strobe is low.
- mem_ack outside MEM_WAIT and io_ack outside IO_WAIT are ignored. mem_ack during IO_WAIT is ignored, and vice versa.
- Reset: state IDLE, counter 0, and every output 0 (wb_ready=1 combinationally from IDLE). Reset mid-handshake drops req at that edge with no err.

## Timing
- Reg/pc/sp latency: accept at edge E0 → strobe high in cycle E0..E1 only.
- Mem/io: req rises at E0 and stays high up to and including the edge at which ack is sampled. Minimum req width is 1 cycle.
- wb_ready is low for every cycle in which req is high.
- Next accept is possible at the edge after ack is sampled.
- Timeout: req high exactly ACK_TIMEOUT cycles, then err high for 1 cycle, coincident with wb_ready returning high.
- Widths: counter is ceil(log2(ACK_TIMEOUT))+1 bits and never wraps.

## Test plan
- Reset with wb_valid=1, dst_sel=010 → all outputs 0, wb_ready=1; no req the cycle after reset deasserts unless a new accept occurs.
- Back-to-back accepts: reg (rd=3, 0xBEEF), pc (0x0100), sp (0xFFFE) → rf_we/rf_waddr=3/0xBEEF, then pc_load/0x0100, then sp_load/0xFFFE, each high 1 cycle in consecutive cycles.
- Mem write addr 0x2000 data 0x1234, ack after 3 req cycles → mem_req high 3 cycles, bus stable, wb_ready low 3 cycles, err never set.
- IO write with io_ack tied 0, ACK_TIMEOUT=15 → io_req high 15 cycles, then err pulse 1 cycle, IDLE. Repeat with ack on cycle 15 → no err.
- dst_sel=001 and 111 → err pulse the next cycle, no strobes/reqs; mem_ack pulsed during IO_WAIT is ignored.
- Assert rst during MEM_WAIT → mem_req 0 at that edge, err 0, wb_ready 1.

Source files
------------

// File: rtl/dst_demux_if.sv
// dst_demux_if: writeback request plus strobe and handshake buses of the destination controller
interface dst_demux_if #(parameter int DATA_W = 16);
  logic              wb_valid;
  logic              wb_ready;
  logic [2:0]        dst_sel;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_addr;
  logic [2:0]        wb_rd;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              io_req;
  logic [DATA_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ack;
  logic              pc_load;
  logic [DATA_W-1:0] pc_next;
  logic              sp_load;
  logic [DATA_W-1:0] sp_next;
  logic              err;
  modport master (
    output wb_valid, dst_sel, wb_data, wb_addr, wb_rd, mem_ack, io_ack,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
           io_req, io_addr, io_wdata, pc_load, pc_next, sp_load, sp_next, err
  );
  modport slave (
    input  wb_valid, dst_sel, wb_data, wb_addr, wb_rd, mem_ack, io_ack,
    output wb_ready, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr, mem_wdata,
           io_req, io_addr, io_wdata, pc_load, pc_next, sp_load, sp_next, err
  );
endinterface

// File: rtl/dst_demux.sv
// dst_demux: routes one writeback word to reg file, memory, I/O, PC or SP with timed req/ack for mem/io
module dst_demux #(
  parameter int ACK_TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst,
  dst_demux_if.slave bus
);
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [1:0] IDLE = 2'd0, MEM_WAIT = 2'd1, IO_WAIT = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          timeout;
  assign bus.wb_ready = state == IDLE;
  assign timeout = cnt == CW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.io_req    <= 1'b0;
      bus.io_addr   <= '0;
      bus.io_wdata  <= '0;
      bus.pc_load   <= 1'b0;
      bus.pc_next   <= '0;
      bus.sp_load   <= 1'b0;
      bus.sp_next   <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.rf_we   <= 1'b0;
      bus.pc_load <= 1'b0;
      bus.sp_load <= 1'b0;
      bus.err     <= 1'b0;
      case (state)
        IDLE: if (bus.wb_valid) begin
          case (bus.dst_sel)
            3'b000: begin
              bus.rf_we    <= 1'b1;
              bus.rf_waddr <= bus.wb_rd;
              bus.rf_wdata <= bus.wb_data;
            end
            3'b010: begin
              bus.mem_req   <= 1'b1;
              bus.mem_addr  <= bus.wb_addr;
              bus.mem_wdata <= bus.wb_data;
              cnt           <= '0;
              state         <= MEM_WAIT;
            end
            3'b011: begin
              bus.io_req   <= 1'b1;
              bus.io_addr  <= bus.wb_addr;
              bus.io_wdata <= bus.wb_data;
              cnt          <= '0;
              state        <= IO_WAIT;
            end
            3'b100: begin
              bus.pc_load <= 1'b1;
              bus.pc_next <= bus.wb_data;
            end
            3'b101: begin
              bus.sp_load <= 1'b1;
              bus.sp_next <= bus.wb_data;
            end
            default: bus.err <= 1'b1;
          endcase
        end
        MEM_WAIT: if (bus.mem_ack || timeout) begin
          bus.mem_req <= 1'b0;
          bus.err     <= !bus.mem_ack;
          state       <= IDLE;
        end else cnt <= cnt + CW'(1);
        IO_WAIT: if (bus.io_ack || timeout) begin
          bus.io_req <= 1'b0;
          bus.err    <= !bus.io_ack;
          state      <= IDLE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
